// File: rtl/lap_timer_if.sv
// Command and status bundle between lap_timer and its controller/display mux.
// master drives commands and presets; slave (the timer) returns live time and lap FIFO state.
interface lap_timer_if #(
  parameter int HOUR_W    = 4,
  parameter int LAP_DEPTH = 4
);
  localparam int CNT_W = $clog2(LAP_DEPTH + 1);

  logic              Mode;
  logic              Start_S;
  logic              Stop_S;
  logic              Reset_S;
  logic              Lap_S;
  logic              Load;
  logic              LapRead;
  logic [HOUR_W-1:0] LoadHours;
  logic [5:0]        LoadMins;
  logic [5:0]        LoadSecs;

  logic [HOUR_W-1:0] Hours;
  logic [5:0]        Mins;
  logic [5:0]        Secs;
  logic [9:0]        MSecs;
  logic              SW_State;
  logic              Expired;
  logic [HOUR_W-1:0] LapHours;
  logic [5:0]        LapMins;
  logic [5:0]        LapSecs;
  logic [9:0]        LapMSecs;
  logic              LapValid;
  logic [CNT_W-1:0]  LapCount;
  logic              LapOverflow;

  modport master (
    output Mode, Start_S, Stop_S, Reset_S, Lap_S, Load, LapRead,
           LoadHours, LoadMins, LoadSecs,
    input  Hours, Mins, Secs, MSecs, SW_State, Expired,
           LapHours, LapMins, LapSecs, LapMSecs, LapValid, LapCount, LapOverflow
  );

  modport slave (
    input  Mode, Start_S, Stop_S, Reset_S, Lap_S, Load, LapRead,
           LoadHours, LoadMins, LoadSecs,
    output Hours, Mins, Secs, MSecs, SW_State, Expired,
           LapHours, LapMins, LapSecs, LapMSecs, LapValid, LapCount, LapOverflow
  );
endinterface

// File: rtl/lap_timer.sv
// Stopwatch / countdown timer with a millisecond prescaler and a lap-snapshot FIFO.
// Up-count saturates at MAX_HOURS:59:59.999; down-count expires on reaching zero.
module lap_timer #(
  parameter int CLK_DIV   = 5,
  parameter int HOUR_W    = 4,
  parameter int MAX_HOURS = 9,
  parameter int LAP_DEPTH = 4
) (
  input logic        Clock_5K,
  input logic        Reset,
  lap_timer_if.slave bus
);
  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W = $clog2(LAP_DEPTH);
  localparam int CNT_W = $clog2(LAP_DEPTH + 1);

  localparam logic [HOUR_W-1:0] MAX_H    = HOUR_W'(MAX_HOURS);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(LAP_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(LAP_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  typedef struct packed {
    logic [HOUR_W-1:0] hours;
    logic [5:0]        mins;
    logic [5:0]        secs;
    logic [9:0]        msecs;
  } stamp_t;

  state_t           state, state_nx;
  stamp_t           cur, cur_nx;
  logic [PRE_W-1:0] presc;
  logic             count_down;

  stamp_t           lap_mem [LAP_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] lap_cnt;
  logic             lap_ovf;

  logic tick, at_max, at_last, is_zero, load_go;
  logic lap_go, full, push, pop;

  assign tick    = (state == RUN) && (presc == PRE_LAST);
  assign is_zero = (cur == '0);
  assign at_max  = (cur.hours == MAX_H) && (cur.mins == 6'd59) &&
                   (cur.secs == 6'd59) && (cur.msecs == 10'd999);
  assign at_last = (cur.hours == '0) && (cur.mins == '0) &&
                   (cur.secs == '0) && (cur.msecs == 10'd1);
  assign load_go = bus.Load && (state == IDLE) && !bus.Reset_S;

  assign lap_go = bus.Lap_S && ((state == RUN) || (state == PAUSE)) && !bus.Reset_S;
  assign full   = (lap_cnt == CNT_FULL);
  assign pop    = bus.LapRead && (lap_cnt != '0) && !bus.Reset_S;
  assign push   = lap_go && (!full || pop);

  // ---------------- FSM: state register ----------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge Clock_5K or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    if (bus.Reset_S) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:  if (!bus.Load && bus.Start_S)
                 state_nx = (bus.Mode && is_zero) ? DONE : RUN;
        // Expiry or saturation outranks a coincident Stop_S.
        RUN:   if (tick && (count_down ? at_last : at_max)) state_nx = DONE;
               else if (bus.Stop_S)                         state_nx = PAUSE;
        PAUSE: if (bus.Start_S) state_nx = RUN;
        DONE:  state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.SW_State = (state == RUN);
    bus.Expired  = (state == DONE);
  end

  // ---------------- time datapath ----------------
  always_comb begin
    cur_nx = cur;
    if (bus.Reset_S) begin
      cur_nx = '0;
    end else if (load_go) begin
      cur_nx.hours = (bus.LoadHours > MAX_H)   ? MAX_H : bus.LoadHours;
      cur_nx.mins  = (bus.LoadMins  > 6'd59)   ? 6'd59 : bus.LoadMins;
      cur_nx.secs  = (bus.LoadSecs  > 6'd59)   ? 6'd59 : bus.LoadSecs;
      cur_nx.msecs = '0;
    end else if (tick && !count_down && !at_max) begin
      if (cur.msecs != 10'd999) cur_nx.msecs = cur.msecs + 10'd1;
      else begin
        cur_nx.msecs = '0;
        if (cur.secs != 6'd59) cur_nx.secs = cur.secs + 6'd1;
        else begin
          cur_nx.secs = '0;
          if (cur.mins != 6'd59) cur_nx.mins = cur.mins + 6'd1;
          else begin
            cur_nx.mins  = '0;
            cur_nx.hours = cur.hours + 1'b1;
          end
        end
      end
    end else if (tick && count_down && !is_zero) begin
      if (cur.msecs != '0) cur_nx.msecs = cur.msecs - 10'd1;
      else begin
        cur_nx.msecs = 10'd999;
        if (cur.secs != '0) cur_nx.secs = cur.secs - 6'd1;
        else begin
          cur_nx.secs = 6'd59;
          if (cur.mins != '0) cur_nx.mins = cur.mins - 6'd1;
          else begin
            cur_nx.mins  = 6'd59;
            cur_nx.hours = cur.hours - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge Clock_5K or posedge Reset) begin
    if (Reset) begin
      cur        <= '0;
      presc      <= '0;
      count_down <= 1'b0;
    end else begin
      cur <= cur_nx;
      if (state == IDLE) count_down <= bus.Mode;
      // Pausing simply freezes the prescaler, so a resume keeps its phase.
      if (bus.Reset_S || ((state == IDLE) && bus.Start_S)) presc <= '0;
      else if (state == RUN) presc <= tick ? '0 : presc + 1'b1;
    end
  end

  assign bus.Hours = cur.hours;
  assign bus.Mins  = cur.mins;
  assign bus.Secs  = cur.secs;
  assign bus.MSecs = cur.msecs;

  // ---------------- lap FIFO ----------------
  // NOTE: the storage array has no reset; lap_cnt gates every read, so stale slots never show.
  always_ff @(posedge Clock_5K) begin
    if (push) lap_mem[wr_ptr] <= cur;
  end

  always_ff @(posedge Clock_5K or posedge Reset) begin
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lap_cnt <= '0;
      lap_ovf <= 1'b0;
    end else if (bus.Reset_S) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lap_cnt <= '0;
      lap_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   lap_cnt <= lap_cnt + 1'b1;
        2'b01:   lap_cnt <= lap_cnt - 1'b1;
        default: lap_cnt <= lap_cnt;
      endcase
      if (lap_go && full && !pop) lap_ovf <= 1'b1;
    end
  end

  always_comb begin
    bus.LapHours = '0;
    bus.LapMins  = '0;
    bus.LapSecs  = '0;
    bus.LapMSecs = '0;
    if (lap_cnt != '0) begin
      bus.LapHours = lap_mem[rd_ptr].hours;
      bus.LapMins  = lap_mem[rd_ptr].mins;
      bus.LapSecs  = lap_mem[rd_ptr].secs;
      bus.LapMSecs = lap_mem[rd_ptr].msecs;
    end
  end

  assign bus.LapValid    = (lap_cnt != '0);
  assign bus.LapCount    = lap_cnt;
  assign bus.LapOverflow = lap_ovf;
endmodule
